// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch align queue.
// Holds the queue entry payload, the aligner state enum, the compressed-
// instruction detect pattern and a small entry constructor.
// The entry address field is sized for the widest supported XLEN (64);
// narrower configurations zero-extend into it.
package ifu_pkg;

  localparam int unsigned IFU_AMAX   = 64;
  localparam int unsigned ILEN       = 32;
  localparam logic [1:0]  RVC_DETECT = 2'b11;  // low bits of a 32-bit encoding

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALF  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [IFU_AMAX-1:0] addr;
    logic [ILEN-1:0]     data;
    logic                is_rvc;
    logic                pf;
  } entry_t;

  function automatic entry_t mk_entry(input logic [IFU_AMAX-1:0] addr,
                                      input logic [ILEN-1:0]     data,
                                      input logic                is_rvc,
                                      input logic                pf);
    entry_t e;
    e.addr   = addr;
    e.data   = data;
    e.is_rvc = is_rvc;
    e.pf     = pf;
    return e;
  endfunction

endpackage

// File: rtl/ifu_inst_fifo.sv
// Circular instruction buffer: up to two writes and one read per cycle.
// Ports: clk, rst (async active-high), flush (sync clear), wr_en0/wr_data0,
//        wr_en1/wr_data1 (wr_en1 only together with wr_en0), rd_en (pop,
//        ignored when empty), head (combinational read of the oldest
//        entry), count (occupied entries).
// The writer guarantees there is room; no overflow protection here.
module ifu_inst_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en0,
  input  entry_t        wr_data0,
  input  logic          wr_en1,
  input  entry_t        wr_data1,
  input  logic          rd_en,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          rd_fire;

  assign rd_fire = rd_en && (count != '0);
  assign head    = mem[rptr];

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wptr] <= wr_data0;
    if (wr_en1) mem[wptr + PW'(1)] <= wr_data1;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(wr_en0) + PW'(wr_en1);
      rptr  <= rptr + PW'(rd_fire);
      count <= count + CW'(wr_en0) + CW'(wr_en1) - CW'(rd_fire);
    end
  end

endmodule

// File: rtl/ifu_align_queue.sv
// Fetch aligner + instruction queue. Splits fetched words into 16/32-bit
// instructions, stitches instructions straddling a word boundary, turns
// translation faults into marker entries and buffers the result.
// Optional feature macro: IFU_RVC_EN (compressed-instruction support).
// Without it every word is one 32-bit instruction and a halfword-aligned
// fetch address is treated as a fault.
// Ports: clk, rst (async active-high); fetch_valid_i/fetch_ready_o with
//        fetch_addr_i, fetch_data_i, fetch_pf_i; flush_i (redirect);
//        inst_valid_o/inst_ready_i with inst_addr_o, inst_data_o,
//        inst_is_rvc_o, inst_pf_o; count_o (occupied entries).
module ifu_align_queue
  import ifu_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned XLEN   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_valid_i,
  input  logic [XLEN-1:0]         fetch_addr_i,
  input  logic [XLEN-1:0]         fetch_data_i,
  input  logic                    fetch_pf_i,
  output logic                    fetch_ready_o,
  input  logic                    flush_i,
  output logic                    inst_valid_o,
  input  logic                    inst_ready_i,
  output logic [XLEN-1:0]         inst_addr_o,
  output logic [31:0]             inst_data_o,
  output logic                    inst_is_rvc_o,
  output logic                    inst_pf_o,
  output logic [$clog2(QDEPTH):0] count_o
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  state_e        state;
  state_e        state_next;
  entry_t        w0;
  entry_t        w1;
  entry_t        head;
  logic          w0_en;
  logic          w1_en;
  logic          accept;
  logic [CW-1:0] free;
  logic [31:0]   word;

  assign word   = 32'(fetch_data_i);
  assign free   = CW'(QDEPTH) - count_o;
  assign accept = fetch_valid_i && fetch_ready_o;

`ifdef IFU_RVC_EN
  logic [15:0]     res_data;
  logic [15:0]     res_data_next;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] res_pc_next;
  logic [XLEN-1:0] hi_pc;
  logic [15:0]     lo;
  logic [15:0]     hi;
  logic            parse_hi;

  assign lo    = word[15:0];
  assign hi    = word[31:16];
  assign hi_pc = {fetch_addr_i[XLEN-1:2], 2'b10};

  // A word can produce two entries, so two free slots are required.
  assign fetch_ready_o = (free >= CW'(2)) && (state != ST_FAULT);

  // Parse the accepted word into up to two entries plus an optional residue.
  always_comb begin
    state_next    = state;
    res_data_next = res_data;
    res_pc_next   = res_pc;
    w0_en         = 1'b0;
    w1_en         = 1'b0;
    w0            = '0;
    w1            = '0;
    parse_hi      = 1'b0;
    if (flush_i) begin
      state_next    = ST_IDLE;
      res_data_next = '0;
      res_pc_next   = '0;
    end else if (accept) begin
      if (fetch_pf_i) begin
        w0_en         = 1'b1;
        w0            = mk_entry(IFU_AMAX'((state == ST_HALF) ? res_pc : fetch_addr_i),
                                 '0, 1'b0, 1'b1);
        state_next    = ST_FAULT;
        res_data_next = '0;
        res_pc_next   = '0;
      end else begin
        state_next = ST_IDLE;
        parse_hi   = 1'b1;
        if (state == ST_HALF) begin
          w0_en = 1'b1;
          w0    = mk_entry(IFU_AMAX'(res_pc), {lo, res_data}, 1'b0, 1'b0);
        end else if (!fetch_addr_i[1]) begin
          w0_en = 1'b1;
          if (lo[1:0] == RVC_DETECT) begin
            w0       = mk_entry(IFU_AMAX'(fetch_addr_i), word, 1'b0, 1'b0);
            parse_hi = 1'b0;
          end else begin
            w0 = mk_entry(IFU_AMAX'(fetch_addr_i), {16'h0000, lo}, 1'b1, 1'b0);
          end
        end
        // Upper half: either a full compressed op or the start of a 32-bit op.
        if (parse_hi) begin
          if (hi[1:0] == RVC_DETECT) begin
            state_next    = ST_HALF;
            res_data_next = hi;
            res_pc_next   = hi_pc;
          end else if (w0_en) begin
            w1_en = 1'b1;
            w1    = mk_entry(IFU_AMAX'(hi_pc), {16'h0000, hi}, 1'b1, 1'b0);
          end else begin
            w0_en = 1'b1;
            w0    = mk_entry(IFU_AMAX'(hi_pc), {16'h0000, hi}, 1'b1, 1'b0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_pc   <= '0;
    end else begin
      res_data <= res_data_next;
      res_pc   <= res_pc_next;
    end
  end

  assign inst_is_rvc_o = inst_valid_o && head.is_rvc;
`else
  logic unused_rvc;

  assign fetch_ready_o = (free >= CW'(1)) && (state != ST_FAULT);

  // One 32-bit instruction per word; a halfword-aligned address cannot be parsed.
  always_comb begin
    state_next = state;
    w0_en      = 1'b0;
    w1_en      = 1'b0;
    w0         = '0;
    w1         = '0;
    if (flush_i) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      w0_en = 1'b1;
      if (fetch_pf_i || fetch_addr_i[1]) begin
        w0         = mk_entry(IFU_AMAX'(fetch_addr_i), '0, 1'b0, 1'b1);
        state_next = ST_FAULT;
      end else begin
        w0 = mk_entry(IFU_AMAX'(fetch_addr_i), word, 1'b0, 1'b0);
      end
    end
  end

  assign unused_rvc    = head.is_rvc;
  assign inst_is_rvc_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  ifu_inst_fifo #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_i),
    .wr_en0   (w0_en),
    .wr_data0 (w0),
    .wr_en1   (w1_en),
    .wr_data1 (w1),
    .rd_en    (inst_ready_i),
    .head     (head),
    .count    (count_o)
  );

  assign inst_valid_o = (count_o != '0);
  assign inst_addr_o  = XLEN'(head.addr);
  assign inst_data_o  = head.data;
  assign inst_pf_o    = inst_valid_o && head.pf;

endmodule

// File: tb/tb_ifu_align_queue.sv
// Directed bench for ifu_align_queue with an expected-entry scoreboard.
// Builds with or without IFU_RVC_EN; compressed scenarios are compiled in
// only when the macro is defined.
module tb_ifu_align_queue;
  import ifu_pkg::*;

  localparam int unsigned QDEPTH = 4;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CW     = $clog2(QDEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] fetch_data;
  logic            fetch_pf;
  logic            fetch_ready;
  logic            flush;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_addr;
  logic [31:0]     inst_data;
  logic            inst_is_rvc;
  logic            inst_pf;
  logic [CW-1:0]   count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rvc;
    logic        pf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ifu_align_queue #(
    .QDEPTH (QDEPTH),
    .XLEN   (XLEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid_i (fetch_valid),
    .fetch_addr_i  (fetch_addr),
    .fetch_data_i  (fetch_data),
    .fetch_pf_i    (fetch_pf),
    .fetch_ready_o (fetch_ready),
    .flush_i       (flush),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_addr_o   (inst_addr),
    .inst_data_o   (inst_data),
    .inst_is_rvc_o (inst_is_rvc),
    .inst_pf_o     (inst_pf),
    .count_o       (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] a, input logic [31:0] d,
                              input logic r, input logic p);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.rvc  = r;
    e.pf   = p;
    sb.push_back(e);
  endtask

  // One clock: optional head check + pop, optional fetch, optional flush.
  // Entered and left at a falling edge with all inputs idle.
  task automatic step(input logic fv, input logic [31:0] a, input logic [31:0] d,
                      input logic pf, input logic pop, input logic fl);
    exp_t e;
    if (pop && sb.size() > 0) begin
      e = sb.pop_front();
      chk("head_valid", 32'(inst_valid), 32'd1);
      chk("head_addr",  inst_addr, e.addr);
      chk("head_data",  inst_data, e.data);
      chk("head_rvc",   32'(inst_is_rvc), 32'(e.rvc));
      chk("head_pf",    32'(inst_pf), 32'(e.pf));
    end
    if (fv) chk("fetch_ready", 32'(fetch_ready), 32'd1);
    fetch_valid = fv;
    fetch_addr  = a;
    fetch_data  = d;
    fetch_pf    = pf;
    inst_ready  = pop;
    flush       = fl;
    @(negedge clk);
    fetch_valid = 1'b0;
    fetch_pf    = 1'b0;
    inst_ready  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(inst_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    fetch_data  = '0;
    fetch_pf    = 1'b0;
    flush       = 1'b0;
    inst_ready  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_pf",    32'(inst_pf), 32'd0);
    chk("rst_rvc",   32'(inst_is_rvc), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 32-bit instruction
    step(1'b1, 32'h8000_0000, 32'h00A0_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0000, 32'h00A0_0093, 1'b0, 1'b0);
    chk("w32_count", 32'(count), 32'd1);
    chk("w32_rvc",   32'(inst_is_rvc), 32'd0);
    drain();

    // Occupancy vs. fetch_ready
    step(1'b1, 32'h8000_0008, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0008, 32'h0010_0093, 1'b0, 1'b0);
    step(1'b1, 32'h8000_000C, 32'h0020_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_000C, 32'h0020_0093, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0010, 32'h0030_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0010, 32'h0030_0093, 1'b0, 1'b0);
    chk("occ3_count", 32'(count), 32'd3);
`ifdef IFU_RVC_EN
    chk("occ3_ready", 32'(fetch_ready), 32'd0);
`else
    chk("occ3_ready", 32'(fetch_ready), 32'd1);
    step(1'b1, 32'h8000_0014, 32'h0040_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0014, 32'h0040_0093, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(fetch_ready), 32'd0);
`endif
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("pop_ready", 32'(fetch_ready), 32'd1);

    // Simultaneous push and pop keeps occupancy
    step(1'b1, 32'h8000_0018, 32'h0050_0093, 1'b0, 1'b1, 1'b0);
    expect_entry(32'h8000_0018, 32'h0050_0093, 1'b0, 1'b0);
    chk("pushpop_count", 32'(count), 32'(sb.size()));
    drain();

    // Push with pop request while empty
    step(1'b1, 32'h8000_0020, 32'h0060_0093, 1'b0, 1'b1, 1'b0);
    expect_entry(32'h8000_0020, 32'h0060_0093, 1'b0, 1'b0);
    chk("empty_pushpop_count", 32'(count), 32'd1);
    drain();

`ifdef IFU_RVC_EN
    // Two compressed instructions in one word
    step(1'b1, 32'h8000_0000, 32'h4501_4501, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0000, 32'h0000_4501, 1'b1, 1'b0);
    expect_entry(32'h8000_0002, 32'h0000_4501, 1'b1, 1'b0);
    chk("rvc2_count", 32'(count), 32'd2);
    chk("rvc2_isrvc", 32'(inst_is_rvc), 32'd1);
    drain();

    // 32-bit instruction straddling two words
    step(1'b1, 32'h8000_0000, 32'h0093_4501, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0000, 32'h0000_4501, 1'b1, 1'b0);
    chk("straddle_count1", 32'(count), 32'd1);
    step(1'b1, 32'h8000_0004, 32'h0000_00A0, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0002, 32'h00A0_0093, 1'b0, 1'b0);
    expect_entry(32'h8000_0006, 32'h0000_0000, 1'b1, 1'b0);
    chk("straddle_count2", 32'(count), 32'd3);
    drain();

    // Redirect to a halfword address parses only the upper half
    step(1'b1, 32'h8000_0102, 32'h4501_0000, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0102, 32'h0000_4501, 1'b1, 1'b0);
    chk("redir_count", 32'(count), 32'd1);
    drain();

    // Fault while a residue is held: marker takes the residue PC
    step(1'b1, 32'h8000_0FFC, 32'h0093_4501, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0FFC, 32'h0000_4501, 1'b1, 1'b0);
    step(1'b1, 32'h8000_1000, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    expect_entry(32'h8000_0FFE, 32'h0000_0000, 1'b0, 1'b1);
    chk("halfpf_count", 32'(count), 32'd2);
    chk("halfpf_ready", 32'(fetch_ready), 32'd0);
    drain();
    chk("halfpf_ready_empty", 32'(fetch_ready), 32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("halfpf_flush_count", 32'(count), 32'd0);
    chk("halfpf_flush_ready", 32'(fetch_ready), 32'd1);
    // Residue gone: next word parses fresh from IDLE
    step(1'b1, 32'h8000_2000, 32'h00A0_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_2000, 32'h00A0_0093, 1'b0, 1'b0);
    chk("postflush_count", 32'(count), 32'd1);
    drain();
`else
    // Halfword-aligned fetch cannot be parsed: fault marker
    step(1'b1, 32'h8000_0002, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_0002, 32'h0000_0000, 1'b0, 1'b1);
    chk("misalign_ready", 32'(fetch_ready), 32'd0);
    drain();
    chk("misalign_ready_empty", 32'(fetch_ready), 32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("misalign_flush_ready", 32'(fetch_ready), 32'd1);
`endif

    // Fault from IDLE: marker at the fetch address, blocked until flush
    step(1'b1, 32'h8000_3000, 32'h00A0_0093, 1'b1, 1'b0, 1'b0);
    expect_entry(32'h8000_3000, 32'h0000_0000, 1'b0, 1'b1);
    chk("pf_count", 32'(count), 32'd1);
    chk("pf_ready", 32'(fetch_ready), 32'd0);
    drain();
    chk("pf_ready_empty", 32'(fetch_ready), 32'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("pf_flush_ready", 32'(fetch_ready), 32'd1);

    // Flush overrides a same-cycle accept and pop
    step(1'b1, 32'h8000_4000, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_4000, 32'h0010_0093, 1'b0, 1'b0);
    step(1'b1, 32'h8000_4004, 32'h0020_0093, 1'b0, 1'b0, 1'b0);
    expect_entry(32'h8000_4004, 32'h0020_0093, 1'b0, 1'b0);
    step(1'b1, 32'h8000_4008, 32'h0030_0093, 1'b0, 1'b1, 1'b1);
    sb.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(inst_valid), 32'd0);

    // Asynchronous reset mid-operation
    step(1'b1, 32'h8000_5000, 32'h0010_0093, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_ready", 32'(fetch_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
